mcu_loader: RTL and testbench
=============================

# mcu_loader

Serial boot loader that sits directly upstream of the 8051 MCU wrapper's 8 KB program ROM. It receives a framed binary image over an 8N1 UART line and writes it byte by byte into the ROM's write port. While a load is in progress it holds the MCU core in reset, and it releases the core only after a frame passes its checksum. Typical use: reprogramming during bring-up without rebuilding the FPGA ROM init file.

## Interface
- `CLK_DIV`, default 313: CLOCK cycles per UART bit (36 MHz / 115200); must be ≥ 4.
- `ADDR_W`, default 13: ROM address width; image capacity is 2^ADDR_W bytes.
- `CLOCK`  in  1: single clock for the whole block.
- `RESET`  in  1: asynchronous, active-high reset.
- `RXD`  in  1: UART receive line, idle high, asynchronous to CLOCK.
- `ROM_WADDR`  out  ADDR_W: ROM write address.
- `ROM_WDATA`  out  8: ROM write data.
- `ROM_WEN`  out  1: one-cycle write strobe, active high.
- `MCU_RESET`  out  1: reset to the MCU core, active high.
- `LOAD_BUSY`  out  1: a frame is in progress.
- `LOAD_ERR`  out  1: the last frame failed; sticky until the next sync byte.

Reset values: `ROM_WADDR`=0, `ROM_WDATA`=0, `ROM_WEN`=0, `MCU_RESET`=0 (the core runs the existing ROM contents), `LOAD_BUSY`=0, `LOAD_ERR`=0.

## Operation
- **Frame format:** sync 0xA5, LEN_H, LEN_L, N data bytes, CSUM.
  - N = {LEN_H, LEN_L}; legal range is 1..2^ADDR_W.
  - CSUM is the 8-bit modulo-256 sum of the data bytes.
- **UART receiver:**
  - `RXD` passes through a 2-flop synchroniser.
  - A falling edge starts bit timing. At CLK_DIV/2 the line is re-checked: still low means a valid start bit; high means a glitch, so return to idle.
  - 8 data bits, LSB first, are sampled every CLK_DIV cycles at mid-bit.
  - The stop bit is sampled at mid-bit. A stop bit of 1 produces a one-cycle `rx_valid` with the byte. A stop bit of 0 produces a one-cycle `rx_ferr` and discards the byte.
  - After the stop sample the receiver is immediately ready for the next start edge.
- **Frame FSM states:** IDLE, LEN_H, LEN_L, DATA, CSUM, ERR.
  - **IDLE:** `rx_valid` with 0xA5 → LEN_H. On entry, set `MCU_RESET`=1 and `LOAD_BUSY`=1, clear `LOAD_ERR`, and clear the address counter and running sum. Any other byte is ignored.
  - **LEN_H:** `rx_valid` → latch the high byte, go to LEN_L.
  - **LEN_L:** `rx_valid` → latch the low byte. If N=0 or N>2^ADDR_W → ERR, otherwise → DATA.
  - **DATA:** each `rx_valid` produces one write, adds the byte to the sum, and decrements the remaining count. After the N-th byte → CSUM.
  - **CSUM:**
    - Byte equals the sum: → IDLE with `MCU_RESET`=0, `LOAD_BUSY`=0, `LOAD_ERR`=0.
    - Byte differs: → ERR.
  - **ERR:** `LOAD_ERR`=1, `LOAD_BUSY`=0, and `MCU_RESET` stays 1 so a partial image never runs. The state behaves as IDLE, so a 0xA5 restarts a frame.
  - **Framing errors:** `rx_ferr` in LEN_H, LEN_L, DATA or CSUM → ERR. In IDLE or ERR it is ignored.
- **Write side:** `ROM_WDATA` and `ROM_WADDR` hold the values of the most recent write between strobes.
- **Arithmetic:**
  - The address counter is ADDR_W bits, counts 0..N-1 and never wraps, because N is range-checked.
  - The remaining count is ADDR_W+1 bits.
  - The sum is 8 bits and wraps modulo 256.
- **Inter-byte timing:** there is no timeout; a stalled frame stays BUSY until more bytes arrive or `RESET` is asserted.
- **Reset mid-frame:** `RESET` returns everything to reset values, including `MCU_RESET`=0. The ROM then holds a partial image; this is acceptable because reset is a debug action.

## Timing
- **RXD to byte:** the `RXD` falling edge reaches `rx_valid` after 2 (synchroniser) + CLK_DIV/2 + 9·CLK_DIV cycles, ±1.
- **Write latency:** `ROM_WEN` asserts the cycle after `rx_valid` of a data byte, with ROM_WADDR=k and ROM_WDATA=byte. The address then becomes k+1 in the cycle after the strobe, ready for the next write.
- **Core release:** `MCU_RESET` falls the cycle after `rx_valid` of a correct CSUM.
- **Core hold:** `MCU_RESET` rises the cycle after `rx_valid` of the sync byte and stays high for the whole frame. The MCU therefore sees a reset of at least 12·CLK_DIV cycles.
- **Strobe rate:** at most one `ROM_WEN` every CLK_DIV·10 cycles; the ROM needs no handshake back.
- **Status outputs:** all outputs are registered with no combinational path from `RXD`.

## Test plan
- **Good 3-byte frame** (CLK_DIV=16): send A5 00 03 11 22 33 66 → writes 0:11, 1:22, 2:33, each `ROM_WEN` exactly 1 cycle wide. `MCU_RESET` is 1 from the sync byte and falls after 0x66. `LOAD_ERR`=0.
- **Bad checksum:** send A5 00 02 10 20 31 → 2 writes occur, then `LOAD_ERR`=1, `MCU_RESET` stays 1, `LOAD_BUSY`=0. Then send the good frame A5 00 01 7F 7F → `LOAD_ERR`=0 and `MCU_RESET`=0.
- **Length errors:** A5 00 00 → ERR with no writes. A5 20 01 (8193, ADDR_W=13) → ERR with no writes. A5 20 00 followed by 8192 bytes → last write at address 0x1FFF, checksum accepted.
- **Noise:**
  - A 0.3·CLK_DIV low glitch on `RXD` in IDLE → no byte, no state change.
  - A stop bit of 0 during DATA → ERR and no write for that byte.
  - Bytes 00 FF 5A before a sync in IDLE → ignored.
- **Async reset:** assert `RESET` in the middle of DATA byte 2 → all outputs return to reset values within the same cycle, including `MCU_RESET`=0. A subsequent full frame loads normally starting at address 0.

Source files
------------

// File: rtl/mcu_loader.sv
`default_nettype none
// ============================================================================
// mcu_loader : UART boot loader that writes a checksummed image into the MCU ROM
// Revision   : 1.0
// ============================================================================
module mcu_loader #(
  parameter int CLK_DIV = 313,
  parameter int ADDR_W  = 13
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              RXD,
  output logic [ADDR_W-1:0] ROM_WADDR,
  output logic [7:0]        ROM_WDATA,
  output logic              ROM_WEN,
  output logic              MCU_RESET,
  output logic              LOAD_BUSY,
  output logic              LOAD_ERR
);

  localparam int          c_cnt_w = $clog2(CLK_DIV + 1);
  localparam int          c_half  = CLK_DIV / 2;
  localparam logic [16:0] c_cap   = 17'(2 ** ADDR_W);
  localparam logic [7:0]  c_sync  = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM, ST_ERR} st_t;

  rx_state_t          r_rx_state;
  logic               r_rxd_meta;
  logic               r_rxd_sync;
  logic               r_rxd_prev;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_rx_valid;
  logic               r_rx_ferr;
  logic [7:0]         r_rx_byte;

  st_t                r_state;
  logic [7:0]         r_len_h;
  logic [ADDR_W:0]    r_remain;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_sum;

  logic [16:0]        w_len;
  logic               w_len_ok;

  assign w_len    = {1'b0, r_len_h, r_rx_byte};
  assign w_len_ok = (w_len != 17'd0) && (w_len <= c_cap);

  // UART receiver: 2-flop synchroniser, start-bit glitch rejection, mid-bit sampling
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rxd_prev && !r_rxd_sync) begin
            r_rx_state <= RX_START;
            r_baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (r_baud_cnt == c_cnt_w'(c_half - 1)) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end
        RX_DATA: begin
          if (r_baud_cnt == c_cnt_w'(CLK_DIV - 1)) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rxd_sync, r_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          if (r_baud_cnt == c_cnt_w'(CLK_DIV - 1)) begin
            r_baud_cnt <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rxd_sync) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_shift;
            end else begin
              r_rx_ferr  <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end
      endcase
    end
  end

  // Frame FSM: MCU stays in reset from the sync byte until a good checksum
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_len_h   <= '0;
      r_remain  <= '0;
      r_addr    <= '0;
      r_sum     <= '0;
      ROM_WADDR <= '0;
      ROM_WDATA <= '0;
      ROM_WEN   <= 1'b0;
      MCU_RESET <= 1'b0;
      LOAD_BUSY <= 1'b0;
      LOAD_ERR  <= 1'b0;
    end else begin
      ROM_WEN <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (r_rx_valid && r_rx_byte == c_sync) begin
            r_state   <= ST_LEN_H;
            r_addr    <= '0;
            r_sum     <= '0;
            MCU_RESET <= 1'b1;
            LOAD_BUSY <= 1'b1;
            LOAD_ERR  <= 1'b0;
          end
        end
        default: begin
          if (r_rx_ferr) begin
            r_state   <= ST_ERR;
            LOAD_BUSY <= 1'b0;
            LOAD_ERR  <= 1'b1;
          end else if (r_rx_valid) begin
            case (r_state)
              ST_LEN_H: begin
                r_len_h <= r_rx_byte;
                r_state <= ST_LEN_L;
              end
              ST_LEN_L: begin
                if (w_len_ok) begin
                  r_remain <= w_len[ADDR_W:0];
                  r_state  <= ST_DATA;
                end else begin
                  r_state   <= ST_ERR;
                  LOAD_BUSY <= 1'b0;
                  LOAD_ERR  <= 1'b1;
                end
              end
              ST_DATA: begin
                ROM_WEN   <= 1'b1;
                ROM_WADDR <= r_addr;
                ROM_WDATA <= r_rx_byte;
                r_addr    <= r_addr + ADDR_W'(1);
                r_sum     <= r_sum + r_rx_byte;
                r_remain  <= r_remain - (ADDR_W + 1)'(1);
                if (r_remain == (ADDR_W + 1)'(1)) r_state <= ST_CSUM;
              end
              default: begin
                LOAD_BUSY <= 1'b0;
                if (r_rx_byte == r_sum) begin
                  r_state   <= ST_IDLE;
                  MCU_RESET <= 1'b0;
                  LOAD_ERR  <= 1'b0;
                end else begin
                  r_state   <= ST_ERR;
                  LOAD_ERR  <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_loader.sv
`default_nettype none
// ============================================================================
// tb_mcu_loader : directed self-checking bench for mcu_loader (CLK_DIV=16, ADDR_W=4)
// Revision      : 1.0
// ============================================================================
module tb_mcu_loader;

  localparam int CLK_DIV = 16;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rxd = 1'b1;
  logic [ADDR_W-1:0] rom_waddr;
  logic [7:0]        rom_wdata;
  logic              rom_wen;
  logic              mcu_reset;
  logic              load_busy;
  logic              load_err;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_wide = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [7:0]        wd[$];
  logic              prev_wen = 1'b0;

  mcu_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .RXD      (rxd),
    .ROM_WADDR(rom_waddr),
    .ROM_WDATA(rom_wdata),
    .ROM_WEN  (rom_wen),
    .MCU_RESET(mcu_reset),
    .LOAD_BUSY(load_busy),
    .LOAD_ERR (load_err)
  );

  always #5 clk = ~clk;

  // Write log sampled on the falling edge; also flags strobes wider than one cycle
  always @(negedge clk) begin
    if (rom_wen) begin
      wa.push_back(rom_waddr);
      wd.push_back(rom_wdata);
      if (prev_wen) n_wide++;
    end
    prev_wen = rom_wen;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    if (!stop) bit_time(1'b1);
  endtask

  task automatic status(input string tag, input logic m, input logic b, input logic e);
    chk({tag, " mcu_reset"}, 32'(mcu_reset), 32'(m));
    chk({tag, " load_busy"}, 32'(load_busy), 32'(b));
    chk({tag, " load_err"},  32'(load_err),  32'(e));
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    // Reset values
    repeat (4) @(negedge clk);
    chk("rst waddr", 32'(rom_waddr), 32'h0);
    chk("rst wdata", 32'(rom_wdata), 32'h0);
    chk("rst wen",   32'(rom_wen),   32'h0);
    status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Good 3-byte frame
    send(8'hA5);
    status("good sync", 1'b1, 1'b1, 1'b0);
    send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    status("good data", 1'b1, 1'b1, 1'b0);
    send(8'h66);
    status("good done", 1'b0, 1'b0, 1'b0);
    chk("good nwr", 32'(wa.size()), 32'd3);
    chk("good a0", 32'(wa[0]), 32'h0); chk("good d0", 32'(wd[0]), 32'h11);
    chk("good a1", 32'(wa[1]), 32'h1); chk("good d1", 32'(wd[1]), 32'h22);
    chk("good a2", 32'(wa[2]), 32'h2); chk("good d2", 32'(wd[2]), 32'h33);
    chk("good hold waddr", 32'(rom_waddr), 32'h2);
    chk("good hold wdata", 32'(rom_wdata), 32'h33);
    clear_log();

    // Bad checksum then recovery
    send(8'hA5); send(8'h00); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    status("badcs", 1'b1, 1'b0, 1'b1);
    chk("badcs nwr", 32'(wa.size()), 32'd2);
    chk("badcs d1",  32'(wd[1]), 32'h20);
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h7F); send(8'h7F);
    status("recover", 1'b0, 1'b0, 1'b0);
    chk("recover a0", 32'(wa[0]), 32'h0);
    chk("recover d0", 32'(wd[0]), 32'h7F);
    clear_log();

    // Length errors: zero, capacity+1, 8193
    send(8'hA5); send(8'h00); send(8'h00);
    status("len0", 1'b1, 1'b0, 1'b1);
    send(8'hA5); send(8'h00); send(8'h11);
    status("len17", 1'b1, 1'b0, 1'b1);
    send(8'hA5); send(8'h20); send(8'h01);
    status("len8193", 1'b1, 1'b0, 1'b1);
    chk("lenerr nwr", 32'(wa.size()), 32'd0);

    // Full-capacity frame: bytes 10..1F, sum 0x178 wraps to 0x78
    send(8'hA5); send(8'h00); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    send(8'h78);
    status("full", 1'b0, 1'b0, 1'b0);
    chk("full nwr",   32'(wa.size()), 32'd16);
    chk("full alast", 32'(wa[15]), 32'hF);
    chk("full dlast", 32'(wd[15]), 32'h1F);
    clear_log();

    // Short low glitch in IDLE, then a frame starting before a false byte would end
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    status("glitch", 1'b0, 1'b0, 1'b0);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h3C); send(8'h3C);
    status("post glitch", 1'b0, 1'b0, 1'b0);
    chk("glitch nwr", 32'(wa.size()), 32'd1);
    chk("glitch d0",  32'(wd[0]), 32'h3C);
    clear_log();

    // Junk bytes in IDLE are ignored
    send(8'h00); send(8'hFF); send(8'h5A);
    status("junk", 1'b0, 1'b0, 1'b0);

    // Stop bit of 0 during DATA
    send(8'hA5); send(8'h00); send(8'h02); send(8'h10);
    send(8'h20, 1'b0);
    status("ferr", 1'b1, 1'b0, 1'b1);
    chk("ferr nwr", 32'(wa.size()), 32'd1);
    clear_log();

    // Asynchronous reset in the middle of data byte 2
    send(8'hA5); send(8'h00); send(8'h03); send(8'hAA);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst waddr", 32'(rom_waddr), 32'h0);
    chk("arst wdata", 32'(rom_wdata), 32'h0);
    chk("arst wen",   32'(rom_wen),   32'h0);
    status("arst", 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h02); send(8'h03);
    status("after arst", 1'b0, 1'b0, 1'b0);
    chk("after arst nwr", 32'(wa.size()), 32'd2);
    chk("after arst a0", 32'(wa[0]), 32'h0); chk("after arst d0", 32'(wd[0]), 32'h01);
    chk("after arst a1", 32'(wa[1]), 32'h1); chk("after arst d1", 32'(wd[1]), 32'h02);

    chk("wen width", 32'(n_wide), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
